// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: LEGv8 fetch stage (PC, imem req/ack, valid/ready issue); define FETCH_TIMEOUT_EN for an ack timeout with sticky fetch_err
module instr_fetch_unit #(
  parameter int ADDR_W = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instruction,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              BrTaken,
  input  logic              UncondBr,
  output logic [ADDR_W-1:0] pc,
  output logic [31:0]       retired,
  output logic              fetch_err
);
`ifdef FETCH_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, FETCH, VALID, ERROR} state_t;
`else
  typedef enum logic [1:0] {IDLE, FETCH, VALID} state_t;
`endif
  state_t state, next_state;
  logic accept;
  logic [ADDR_W-1:0] off_b, off_cb, next_pc;
  assign accept = state == VALID && instr_ready;
  assign imem_req = state == FETCH;
  assign imem_addr = pc;
  assign instr_valid = state == VALID;
  assign off_b = {{(ADDR_W-28){instruction[25]}}, instruction[25:0], 2'b00};
  assign off_cb = {{(ADDR_W-21){instruction[23]}}, instruction[23:5], 2'b00};
  // BrTaken gates the select so UncondBr is irrelevant on a sequential fetch
  assign next_pc = pc + (BrTaken ? (UncondBr ? off_b : off_cb) : ADDR_W'(4));
`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tcnt;
  logic timeout;
  assign timeout = state == FETCH && !imem_ack && tcnt == CNT_W'(TIMEOUT_CYCLES - 1);
  // ack wait counter (zero outside FETCH) and sticky error flag
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      tcnt <= '0;
      fetch_err <= 1'b0;
    end else begin
      tcnt <= (state == FETCH && !imem_ack) ? tcnt + 1'b1 : '0;
      fetch_err <= fetch_err | timeout;
    end
`else
  assign fetch_err = 1'b0;
`endif
  // next-state logic: one fetch outstanding, no prefetch
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = FETCH;
      FETCH:   next_state = imem_ack ? VALID : FETCH;
      VALID:   next_state = instr_ready ? FETCH : VALID;
      default: next_state = state;
    endcase
`ifdef FETCH_TIMEOUT_EN
    if (timeout) next_state = ERROR;
`endif
  end
  // state, captured instruction, pc and retire counter
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      pc <= RESET_PC;
      instruction <= '0;
      retired <= '0;
    end else begin
      state <= next_state;
      if (state == FETCH && imem_ack) instruction <= imem_rdata;
      if (accept) begin
        pc <= next_pc;
        retired <= retired + 32'd1;
      end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: random imem/decoder stimulus with scoreboard against a branch-arithmetic reference model
module tb_instr_fetch_unit;
  logic clk = 0, reset_n = 0, imem_ack = 0, instr_ready = 0, BrTaken = 0, UncondBr = 0;
  logic [31:0] imem_rdata = 0;
  logic imem_req, instr_valid, fetch_err;
  logic [63:0] imem_addr, pc;
  logic [31:0] instruction, retired;
  int total = 0, bad = 0, accepts = 0, expected_accepts = 0;
  bit to_phase = 0;
  typedef struct {logic [31:0] ins; logic [63:0] pc; logic [31:0] ret;} acc_t;
  logic [63:0] q_fetch[$];
  acc_t q_acc[$];
  logic [63:0] model_pc;
  logic [31:0] model_ret;

  instr_fetch_unit dut (
    .clk(clk), .reset_n(reset_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instruction(instruction),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .BrTaken(BrTaken),
    .UncondBr(UncondBr), .pc(pc), .retired(retired), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // reference: branch offsets are signed word counts scaled by 4, adds wrap at 64 bits
  function automatic logic [63:0] ref_next(input logic [63:0] p, input logic [31:0] d, input bit br, input bit uc);
    longint off;
    logic [25:0] i26;
    logic [18:0] i19;
    i26 = d[25:0];
    i19 = d[23:5];
    if (!br) off = 4;
    else if (uc) off = longint'($signed(i26)) * 4;
    else off = longint'($signed(i19)) * 4;
    return p + 64'(off);
  endfunction

  // called #1 after a posedge with the DUT in FETCH
  task automatic do_instr(input logic [31:0] d, input bit br, input bit uc, input int ad, input int rd);
    acc_t a;
    repeat (ad) begin @(posedge clk); #1; end
    imem_ack = 1;
    imem_rdata = d;
    q_fetch.push_back(model_pc);
    a.ins = d; a.pc = model_pc; a.ret = model_ret;
    q_acc.push_back(a);
    @(posedge clk); #1;
    imem_ack = 0;
    imem_rdata = $urandom;
    repeat (rd) begin
      BrTaken = 1'($urandom); UncondBr = 1'($urandom);
      @(posedge clk); #1;
    end
    instr_ready = 1; BrTaken = br; UncondBr = uc;
    @(posedge clk); #1;
    instr_ready = 0; BrTaken = 1'($urandom); UncondBr = 1'($urandom);
    model_pc = ref_next(model_pc, d, br, uc);
    model_ret = model_ret + 1;
    expected_accepts++;
  endtask

  // monitor: pops expected fetch addresses and issued instructions
  always @(negedge clk) if (reset_n) begin
    if (imem_req && imem_ack) begin
      if (q_fetch.size() == 0) check("unexpected_fetch", 1, 0);
      else check("imem_addr", imem_addr, q_fetch.pop_front());
    end
    if (instr_valid) begin
      if (q_acc.size() == 0) check("unexpected_valid", 1, 0);
      else begin
        check("instruction", instruction, q_acc[0].ins);
        check("pc_valid", pc, q_acc[0].pc);
        check("retired", retired, q_acc[0].ret);
        check("req_in_valid", imem_req, 0);
        if (instr_ready) begin
          void'(q_acc.pop_front());
          accepts++;
        end
      end
    end
    if (!to_phase) check("fetch_err", fetch_err, 0);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", instr_valid, 0);
    check("rst_req", imem_req, 0);
    check("rst_pc", pc, 0);
    check("rst_retired", retired, 0);
    check("rst_instruction", instruction, 0);
    check("rst_fetch_err", fetch_err, 0);
    reset_n = 1; model_pc = 0; model_ret = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) do_instr($urandom, 0, 1'($urandom), 0, 0);
    check("retired_after_4", retired, 4);
    check("pc_after_4", pc, 64'h10);
    do_instr(32'h1400000C, 1, 1, 1, 2);
    check("pc_b_to_40", pc, 64'h40);
    do_instr(32'h17FFFFFE, 1, 1, 0, 0);
    check("pc_b_minus2", imem_addr, 64'h38);
    do_instr(32'h14000032, 1, 1, 2, 0);
    check("pc_b_to_100", pc, 64'h100);
    do_instr(32'hB4000060, 1, 0, 0, 1);
    check("pc_cbz_taken", pc, 64'h10C);
    do_instr(32'h17FFFFFD, 1, 1, 0, 0);
    check("pc_b_back", pc, 64'h100);
    do_instr(32'hB4000060, 0, 1, 0, 5);
    check("pc_cbz_not_taken", pc, 64'h104);
    for (int i = 0; i < 150; i++)
      do_instr($urandom, $urandom_range(0, 1) == 1, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
    @(posedge clk); #1;
    reset_n = 0;
    #1;
    check("async_rst_pc", pc, 0);
    check("async_rst_retired", retired, 0);
    check("async_rst_req", imem_req, 0);
    imem_ack = 1; imem_rdata = $urandom;
    repeat (2) begin @(posedge clk); #1; end
    check("late_ack_valid", instr_valid, 0);
    check("late_ack_pc", pc, 0);
    reset_n = 1; model_pc = 0; model_ret = 0;
    @(posedge clk); #1;
    check("idle_ack_ignored", instr_valid, 0);
    imem_ack = 0;
    for (int i = 0; i < 6; i++)
      do_instr($urandom, $urandom_range(0, 1) == 1, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
`ifdef FETCH_TIMEOUT_EN
    to_phase = 1;
    repeat (18) begin @(posedge clk); #1; end
    check("timeout_err", fetch_err, 1);
    check("timeout_req", imem_req, 0);
    check("timeout_valid", instr_valid, 0);
    reset_n = 0;
    #1;
    check("timeout_err_cleared", fetch_err, 0);
`endif
    check("accept_count", accepts, expected_accepts);
    check("fetch_q_empty", q_fetch.size(), 0);
    check("acc_q_empty", q_acc.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction fetch stage that supplies 32-bit LEGv8 instructions to the control decoder. It holds the program counter and runs a request/acknowledge fetch handshake to instruction memory.
- Presents each instruction with a valid/ready handshake. On acceptance it samples the decoder's BrTaken/UncondBr to compute the next PC.
- This block is the producing end of the decoder's instruction input and the consumer of its branch outputs.

Parameters:
- ADDR_W, 64, PC and imem address width in bits
- RESET_PC, 0, PC value loaded on reset
- TIMEOUT_CYCLES, 16, max imem_ack wait; used only when FETCH_TIMEOUT_EN is defined

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- imem_req  output  1  fetch request, held high until imem_ack
- imem_addr  output  ADDR_W  fetch address, equals pc while imem_req is high
- imem_ack  input  1  memory returns imem_rdata this cycle
- imem_rdata  input  32  fetched instruction word
- instruction  output  32  instruction to decoder, stable while instr_valid is high
- instr_valid  output  1  instruction holds a valid word
- instr_ready  input  1  downstream accepts instruction this cycle
- BrTaken  input  1  from decoder, sampled on accept
- UncondBr  input  1  from decoder, sampled on accept
- pc  output  ADDR_W  address of the current or pending instruction
- retired  output  32  count of accepted instructions
- fetch_err  output  1  sticky timeout flag; tied 0 when the optional feature is compiled out

Behaviour:
- Reset (async, reset_n low):
  - state=IDLE, pc=RESET_PC, instruction=0, instr_valid=0, imem_req=0, retired=0, fetch_err=0.
  - Any in-flight fetch is abandoned; a late imem_ack is ignored because it arrives in IDLE.
- States:
  - IDLE -> FETCH unconditionally on the first clock after reset release.
  - FETCH: imem_req=1, imem_addr=pc. On imem_ack, register imem_rdata into instruction, set instr_valid=1, go to VALID. Without ack, stay.
  - VALID: instr_valid=1, imem_req=0. If instr_ready=0, hold instruction and pc unchanged. If instr_ready=1, this is an accept.
- On accept:
  - retired increments and wraps at 2^32-1 -> 0.
  - instr_valid drops next cycle.
  - pc updates to the next PC.
  - state returns to FETCH.
- Next PC:
  - BrTaken=0: pc+4.
  - BrTaken=1, UncondBr=1: pc + (sign_extend(instruction[25:0]) << 2).
  - BrTaken=1, UncondBr=0: pc + (sign_extend(instruction[23:5]) << 2).
- Arithmetic: all adds are modulo 2^ADDR_W; wrap-around is silent, with no error.
- BrTaken/UncondBr are combinational from the decoder and are used only in the accept cycle. X on UncondBr while BrTaken=0 must not affect pc.
- Latency and throughput:
  - Minimum 2 cycles from request to valid: ack in the request cycle, valid the next cycle.
  - Maximum throughput is one instruction per 2 cycles. There is no prefetch, so a branch needs no flush.
- Simultaneous events: imem_ack is ignored outside FETCH; instr_ready is ignored outside VALID.
- pc updates only on accept or reset.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to FETCH and increments each FETCH cycle without ack.
  - When it reaches TIMEOUT_CYCLES: set fetch_err=1 (sticky until reset), drop imem_req, enter state ERROR.
  - ERROR: no outputs change and the block stays there until reset_n is asserted.
- Undefined: no counter, no ERROR state, fetch_err tied 0, FETCH waits indefinitely.

Test Plan:
- Reset release, imem_ack=1 on every request, instr_ready=1, all BrTaken=0 -> imem_addr sequence 0,4,8,12; retired=4 after the 4th accept; instr_valid pulses every 2nd cycle.
- At pc=0x40, instruction 0x17FFFFFE (B, imm26=-2), BrTaken=1, UncondBr=1 -> next imem_addr=0x38.
- At pc=0x100, instruction 0xB4000060 (CBZ, imm19=3): BrTaken=1, UncondBr=0 -> next pc=0x10C; BrTaken=0 -> next pc=0x104.
- instr_ready held 0 for 5 cycles in VALID -> instruction and pc unchanged, imem_req=0, retired unchanged; the accept on cycle 6 advances.
- reset_n low in FETCH before ack, then ack arrives while in reset/IDLE -> instr_valid stays 0, pc=RESET_PC; the fetch restarts at RESET_PC.
- FETCH_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, imem_ack never asserted -> fetch_err=1 after 16 FETCH cycles, imem_req=0; reset clears fetch_err.
